// File: rtl/counter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared types and constants for the counter button control stage.
//             Defines the per-button debounce state encoding, the default
//             debounce length and the direction encodings driven onto `ud`.
//  Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

   // Debounce FSM states, one FSM per pushbutton.
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // 20 ms worth of stable samples at a 100 kHz system clock.
   localparam int   DEBOUNCE_CYCLES_DEFAULT = 2000;

   // Direction encodings presented to the counter on `ud`.
   localparam logic UD_UP   = 1'b1;
   localparam logic UD_DOWN = 1'b0;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Purpose  : Conditions one raw active-low pushbutton. A 2-flop synchronizer
//             brings the pin into the clk domain, a 4-state FSM with a
//             saturating counter requires DEBOUNCE_CYCLES consecutive stable
//             samples to accept a press or a release, and exactly one
//             one-cycle pulse is produced per accepted press.
//  Ports    : clk      in   system clock, rising edge
//             reset_n  in   asynchronous active-low reset
//             btn_n    in   raw button pin, active-low, asynchronous to clk
//             pulse    out  one-cycle strobe per accepted press (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module button_debounce
   import counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_n,
   output logic pulse
);

   localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  c_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  c_CNT_ONE = CW'(1);

   logic          r_sync1;
   logic          r_sync2;
   btn_state_t    r_state;
   btn_state_t    w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_pulse;
   logic          w_pulse_nxt;
   logic          w_pressed;

   // Synchronizer resets to 1 so a button held through reset is seen as a
   // fresh press once reset lifts and must be debounced from IDLE.
   assign w_pressed = ~r_sync2;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pressed) begin
               w_state_nxt = PRESS_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!w_pressed) begin
               // Glitch: drop back without a pulse.
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_MAX) begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
               w_pulse_nxt = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end
         PRESSED: begin
            if (!w_pressed) begin
               w_state_nxt = RELEASE_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (w_pressed) begin
               // Release bounce: still the same press, no new pulse.
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_MAX) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= btn_n;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   assign pulse = r_pulse;

endmodule : button_debounce
`default_nettype wire

// File: rtl/counter_button_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : counter_button_ctrl
//  Purpose  : Upstream control stage for the up/down counter. Debounces the
//             start/stop and direction pushbuttons and turns each accepted
//             press into a toggle of the matching level control.
//  Ports    : clk          in   system clock, rising edge
//             reset_n      in   asynchronous active-low reset
//             btn_start_n  in   raw start/stop button, active-low
//             btn_ud_n     in   raw direction button, active-low
//             start        out  run enable, toggles per accepted start press
//             ud           out  direction (1 = up), toggles per ud press
//             start_pulse  out  one-cycle strobe per accepted start press
//             ud_pulse     out  one-cycle strobe per accepted ud press
//  Revision : 1.0 - initial release
// ============================================================================
module counter_button_ctrl
   import counter_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter logic START_INIT      = 1'b0,
   parameter logic UD_INIT         = UD_UP
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_start_n,
   input  logic btn_ud_n,
   output logic start,
   output logic ud,
   output logic start_pulse,
   output logic ud_pulse
);

   logic w_start_pulse;
   logic w_ud_pulse;
   logic r_start_base;
   logic r_ud_base;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_start_btn (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_n   (btn_start_n),
      .pulse   (w_start_pulse)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_ud_btn (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_n   (btn_ud_n),
      .pulse   (w_ud_pulse)
   );

   // The base registers absorb each pulse one edge after it rises.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_start_base <= START_INIT;
         r_ud_base    <= UD_INIT;
      end else begin
         r_start_base <= r_start_base ^ w_start_pulse;
         r_ud_base    <= r_ud_base ^ w_ud_pulse;
      end
   end

   // XOR with the live pulse makes the level change on the same edge the
   // pulse rises, then the base register holds the new value afterwards.
   assign start       = r_start_base ^ w_start_pulse;
   assign ud          = r_ud_base ^ w_ud_pulse;
   assign start_pulse = w_start_pulse;
   assign ud_pulse    = w_ud_pulse;

endmodule : counter_button_ctrl
`default_nettype wire

// File: tb/tb_counter_button_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_counter_button_ctrl
//  Purpose  : Scoreboard bench for counter_button_ctrl with DEBOUNCE_CYCLES=4
//             and a 10 us clock. Stimulus pushes the expected pulse cycle and
//             channels into a queue; the monitor pops on every pulse and also
//             tracks the start/ud levels every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_button_ctrl;
   import counter_pkg::*;

   localparam int D = 4;

   logic clk         = 1'b0;
   logic reset_n     = 1'b1;
   logic btn_start_n = 1'b1;
   logic btn_ud_n    = 1'b1;
   logic start, ud, start_pulse, ud_pulse;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int   cyc;
      logic sp;
      logic up;
   } ev_t;

   ev_t  q[$];
   ev_t  mon_e;
   logic m_start = 1'b0;
   logic m_ud    = UD_UP;

   counter_button_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .START_INIT      (1'b0),
      .UD_INIT         (1'b1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_start_n (btn_start_n),
      .btn_ud_n    (btn_ud_n),
      .start       (start),
      .ud          (ud),
      .start_pulse (start_pulse),
      .ud_pulse    (ud_pulse)
   );

   always #5000 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Called at a falling edge just as buttons are driven low, i.e. before
   // edge N = cyc+1; the pulse must be high in the cycle after edge N+D+2.
   task automatic expect_pulse(input logic sp, input logic up);
      ev_t e;
      e.cyc = cyc + 1 + D + 2;
      e.sp  = sp;
      e.up  = up;
      q.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_start"},       {31'd0, start},       32'd0);
      check({tag, "_ud"},          {31'd0, ud},          32'd1);
      check({tag, "_start_pulse"}, {31'd0, start_pulse}, 32'd0);
      check({tag, "_ud_pulse"},    {31'd0, ud_pulse},    32'd0);
   endtask

   // Monitor: pops one expectation per pulse cycle, checks levels every cycle.
   always @(negedge clk) begin
      if (!reset_n) begin
         m_start = 1'b0;
         m_ud    = UD_UP;
      end else if (start_pulse || ud_pulse) begin
         if (q.size() == 0) begin
            check("unexpected_pulse", {30'd0, start_pulse, ud_pulse}, 32'd0);
         end else begin
            mon_e = q.pop_front();
            check("pulse_cycle", cyc, mon_e.cyc);
            check("start_pulse", {31'd0, start_pulse}, {31'd0, mon_e.sp});
            check("ud_pulse",    {31'd0, ud_pulse},    {31'd0, mon_e.up});
            if (mon_e.sp) m_start = ~m_start;
            if (mon_e.up) m_ud    = ~m_ud;
            check("start_level_at_pulse", {31'd0, start}, {31'd0, m_start});
            check("ud_level_at_pulse",    {31'd0, ud},    {31'd0, m_ud});
         end
      end else begin
         check("start_level", {31'd0, start}, {31'd0, m_start});
         check("ud_level",    {31'd0, ud},    {31'd0, m_ud});
      end
   end

   initial begin
      // Asynchronous reset, asserted well before the first rising edge.
      #500  reset_n = 1'b0;
      #1000 check_reset_vals("reset_async");
      @(negedge clk);
      #1000 reset_n = 1'b1;
      wait_cycles(3);

      // Clean press held 20 cycles: one pulse, start 0->1.
      btn_start_n = 1'b0;
      expect_pulse(1'b1, 1'b0);
      wait_cycles(20);
      btn_start_n = 1'b1;
      wait_cycles(12);

      // Direction glitch of 3 cycles is rejected.
      btn_ud_n = 1'b0;
      wait_cycles(3);
      btn_ud_n = 1'b1;
      wait_cycles(8);

      // 6 cycles low is accepted: ud 1->0.
      btn_ud_n = 1'b0;
      expect_pulse(1'b0, 1'b1);
      wait_cycles(6);
      btn_ud_n = 1'b1;
      wait_cycles(12);

      // Accepted press followed by release bounce: no extra pulses.
      btn_start_n = 1'b0;
      expect_pulse(1'b1, 1'b0);
      wait_cycles(10);
      for (int i = 0; i < 3; i++) begin
         btn_start_n = 1'b1;
         wait_cycles(2);
         btn_start_n = 1'b0;
         wait_cycles(2);
      end
      wait_cycles(6);
      btn_start_n = 1'b1;
      wait_cycles(10);
      // Re-armed: second press is accepted.
      btn_start_n = 1'b0;
      expect_pulse(1'b1, 1'b0);
      wait_cycles(10);
      btn_start_n = 1'b1;
      wait_cycles(12);

      // Simultaneous presses pulse and toggle together.
      btn_start_n = 1'b0;
      btn_ud_n    = 1'b0;
      expect_pulse(1'b1, 1'b1);
      wait_cycles(10);
      btn_start_n = 1'b1;
      btn_ud_n    = 1'b1;
      wait_cycles(12);

      // Reset in the middle of a pulse cycle, button kept held.
      btn_start_n = 1'b0;
      expect_pulse(1'b1, 1'b0);
      wait_cycles(7);
      #1000 reset_n = 1'b0;
      #1000 check_reset_vals("reset_mid_pulse");
      @(negedge clk);
      // Held button must be re-debounced from the first post-reset edge.
      expect_pulse(1'b1, 1'b0);
      #1000 reset_n = 1'b1;
      wait_cycles(10);
      btn_start_n = 1'b1;
      wait_cycles(12);

      // Reset while the ud channel is in PRESS_WAIT (just after edge N+4).
      btn_ud_n = 1'b0;
      wait_cycles(4);
      @(posedge clk);
      #1000 reset_n = 1'b0;
      #1000 check_reset_vals("reset_press_wait");
      @(negedge clk);
      expect_pulse(1'b0, 1'b1);
      #1000 reset_n = 1'b1;
      wait_cycles(12);
      btn_ud_n = 1'b1;
      wait_cycles(12);

      check("pending_pulses", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_counter_button_ctrl
`default_nettype wire
